// File: rtl/i2c_command_scheduler_if.sv
// Requester handshakes and transmitter command bus for i2c_command_scheduler.
// The scheduler connects through the slave modport; requesters and the bench use the master modport.
interface i2c_command_scheduler_if;
   logic        req0;
   logic [7:0]  req0_register;
   logic [15:0] req0_data;
   logic        ack0;
   logic        done0;
   logic        req1;
   logic [7:0]  req1_register;
   logic [15:0] req1_data;
   logic        ack1;
   logic        done1;
   logic        send_i2c;
   logic [7:0]  i2c_register;
   logic [15:0] i2c_data;
   logic        busy;
   logic        init_done;

   modport slave (
      input  req0, req0_register, req0_data, req1, req1_register, req1_data,
      output ack0, done0, ack1, done1, send_i2c, i2c_register, i2c_data, busy, init_done
   );

   modport master (
      output req0, req0_register, req0_data, req1, req1_register, req1_data,
      input  ack0, done0, ack1, done1, send_i2c, i2c_register, i2c_data, busy, init_done
   );
endinterface

// File: rtl/i2c_command_scheduler.sv
// Replays the camera init table, then shares the feedback-less I2C transmitter between
// two round-robin requesters, timing each write window purely by cycle count.
module i2c_command_scheduler #(
   parameter int unsigned TXN_CYCLES  = 450000,
   parameter int unsigned GAP_CYCLES  = 10000,
   parameter bit          ENABLE_INIT = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   i2c_command_scheduler_if.slave bus
);

   typedef enum logic [1:0] {S_INIT_ISSUE, S_IDLE, S_HOLD, S_GAP} state_t;
   typedef enum logic [1:0] {OWN_INIT, OWN_REQ0, OWN_REQ1} owner_t;

   localparam state_t      RESET_STATE = state_t'(ENABLE_INIT ? S_INIT_ISSUE : S_IDLE);
   localparam logic [19:0] TXN_LAST    = 20'(TXN_CYCLES - 1);
   localparam logic [19:0] GAP_LAST    = 20'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   logic [2:0]  idx_q, idx_d;
   logic [19:0] cnt_q, cnt_d;
   logic        rr_last_q, rr_last_d;
   logic        send_q, send_d;
   logic [7:0]  reg_q, reg_d;
   logic [15:0] data_q, data_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic        init_done_q, init_done_d;

   logic [7:0]  tbl_reg;
   logic [15:0] tbl_data;
   logic        grant0, grant1;

   always_comb begin
      tbl_reg  = 8'h00;
      tbl_data = 16'h0000;
      case (idx_q)
         3'd0: begin tbl_reg = 8'h23; tbl_data = 16'h0033; end
         3'd1: begin tbl_reg = 8'h22; tbl_data = 16'h0033; end
         3'd2: begin tbl_reg = 8'h04; tbl_data = 16'h09FF; end
         3'd3: begin tbl_reg = 8'h03; tbl_data = 16'h077F; end
         3'd4: begin tbl_reg = 8'h01; tbl_data = 16'h0038; end
         3'd5: begin tbl_reg = 8'h20; tbl_data = 16'h0060; end
         3'd6: begin tbl_reg = 8'h1E; tbl_data = 16'h4146; end
         default: begin tbl_reg = 8'h0A; tbl_data = 16'h8000; end
      endcase
   end

   // On a tie the requester that was not granted last wins.
   assign grant0 = bus.req0 & (~bus.req1 | rr_last_q);
   assign grant1 = bus.req1 & (~bus.req0 | ~rr_last_q);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q + 20'd1;
      rr_last_d   = rr_last_q;
      send_d      = send_q;
      reg_d       = reg_q;
      data_d      = data_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      init_done_d = init_done_q;

      case (state_q)
         S_INIT_ISSUE: begin
            reg_d   = tbl_reg;
            data_d  = tbl_data;
            send_d  = 1'b1;
            cnt_d   = '0;
            owner_d = OWN_INIT;
            state_d = S_HOLD;
         end
         S_IDLE: begin
            send_d = 1'b0;
            cnt_d  = '0;
            if (grant0) begin
               reg_d     = bus.req0_register;
               data_d    = bus.req0_data;
               ack0_d    = 1'b1;
               rr_last_d = 1'b0;
               send_d    = 1'b1;
               owner_d   = OWN_REQ0;
               state_d   = S_HOLD;
            end else if (grant1) begin
               reg_d     = bus.req1_register;
               data_d    = bus.req1_data;
               ack1_d    = 1'b1;
               rr_last_d = 1'b1;
               send_d    = 1'b1;
               owner_d   = OWN_REQ1;
               state_d   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_q == TXN_LAST) begin
               send_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            send_d = 1'b0;
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               case (owner_q)
                  OWN_INIT: begin
                     if (idx_q == 3'd7) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                     end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_INIT_ISSUE;
                     end
                  end
                  OWN_REQ0: begin
                     done0_d = 1'b1;
                     state_d = S_IDLE;
                  end
                  OWN_REQ1: begin
                     done1_d = 1'b1;
                     state_d = S_IDLE;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RESET_STATE;
         owner_q     <= OWN_INIT;
         idx_q       <= '0;
         cnt_q       <= '0;
         rr_last_q   <= 1'b1;
         send_q      <= 1'b0;
         reg_q       <= '0;
         data_q      <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         init_done_q <= ~ENABLE_INIT;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         rr_last_q   <= rr_last_d;
         send_q      <= send_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         init_done_q <= init_done_d;
      end
   end

   assign bus.send_i2c     = send_q;
   assign bus.i2c_register = reg_q;
   assign bus.i2c_data     = data_q;
   assign bus.ack0         = ack0_q;
   assign bus.ack1         = ack1_q;
   assign bus.done0        = done0_q;
   assign bus.done1        = done1_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.init_done    = init_done_q;

endmodule
